// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a synchronous FIFO (1-clk read latency) into a
// valid/ready stream. A 3-entry skid buffer plus an in-flight flag lets the
// reader issue pops without looking at m_ready, which keeps m_ready out of
// the fifo_rd_en path while still sustaining one word per clock.
// m_last marks the final beat of each BURST_LEN-beat burst.
module fifo_stream_reader #(
  parameter int DATA_WIDE = 64,
  parameter int BURST_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATA_WIDE-1:0] fifo_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DATA_WIDE-1:0] m_data,
  output logic                 m_last,
  output logic [1:0]           level
);

  localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

  logic [DATA_WIDE-1:0] mem [3];
  logic [1:0]           head;
  logic [1:0]           tail;
  logic [1:0]           count;
  logic                 inflight;
  logic                 run;       // low until the first edge after reset release
  logic [7:0]           beat;
  logic [2:0]           occupancy;
  logic                 capture;
  logic                 pop;

  // Pointers walk 0,1,2,0,...
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Pop request, capture/pop strobes and the stream outputs, all decoded from
  // registered state plus the upstream empty flag and flush.
  // NOTE: every signal gets a default first, so no path leaves one unassigned
  // and no latch is inferred.
  always_comb begin
    occupancy  = {1'b0, count} + {2'b00, inflight};
    fifo_rd_en = 1'b0;
    if (run && !fifo_empty && !flush && (occupancy < 3'd3)) begin
      fifo_rd_en = 1'b1;
    end
    m_valid = (count != 2'd0);
    m_data  = m_valid ? mem[head] : '0;
    m_last  = m_valid && (beat == LAST_BEAT);
    level   = count;
    capture = inflight && !flush;
    pop     = m_valid && m_ready && !flush;
  end

  // Control state: pointers, occupancy, in-flight flag and beat counter.
  // NOTE: registered state uses non-blocking assignments so every flop sees
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= 2'd0;
      tail     <= 2'd0;
      count    <= 2'd0;
      inflight <= 1'b0;
      beat     <= 8'd0;
      run      <= 1'b0;
    end else begin
      run      <= 1'b1;
      // fifo_rd_en is already forced low during flush, so this also clears it.
      inflight <= fifo_rd_en;
      if (flush) begin
        head  <= 2'd0;
        tail  <= 2'd0;
        count <= 2'd0;
        beat  <= 8'd0;
      end else begin
        if (capture) begin
          tail <= ptr_inc(tail);
        end
        if (pop) begin
          head <= ptr_inc(head);
          beat <= (beat == LAST_BEAT) ? 8'd0 : beat + 8'd1;
        end
        // Capture and pop together leave the count unchanged.
        unique case ({capture, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // Buffer storage: the returning FIFO word lands in the tail entry.
  // NOTE: storage is deliberately not reset; count tracks which entries are
  // meaningful and m_data is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (capture) begin
      mem[tail] <= fifo_dout;
    end
  end

endmodule
